// File: rtl/regfile_ctx_engine_if.sv
// Register-file port bundle (read port S, write port D) plus the SAVE/RESTORE word streams.
// master = context engine side, slave = register file / stream partner side.
interface regfile_ctx_engine_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rf_s_addr;
    logic [DATA_W-1:0] rf_s_data;
    logic [DATA_W-1:0] rf_d;
    logic [ADDR_W-1:0] rf_d_addr;
    logic              rf_d_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output rf_s_addr, rf_d, rf_d_addr, rf_d_en, out_data, out_valid, in_ready,
        input  rf_s_data, out_ready, in_data, in_valid
    );

    modport slave (
        input  rf_s_addr, rf_d, rf_d_addr, rf_d_en, out_data, out_valid, in_ready,
        output rf_s_data, out_ready, in_data, in_valid
    );
endinterface

// File: rtl/regfile_ctx_engine.sv
// Context save/restore sequencer: streams a register range out (SAVE) or writes a stream into it (RESTORE).
// Define CTX_CHECKSUM_EN to build the running XOR checksum; otherwise checksum is tied to 0.
module regfile_ctx_engine #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [ADDR_W-1:0]    first_reg,
    input  logic [ADDR_W-1:0]    last_reg,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      word_count,
    output logic [DATA_W-1:0]    checksum,
    regfile_ctx_engine_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SAVE    = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_RESTORE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE  = (ADDR_W+1)'(1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] end_reg;
    logic [DATA_W-1:0] out_data_r;
    logic              out_valid_r;
    logic              cmd_accept;
    logic              capture;
    logic              in_hs;

    assign cmd_accept = (state == S_IDLE) && start;
    // A new word may be captured whenever the output slot is empty or being emptied this cycle.
    assign capture    = (state == S_SAVE) && (!out_valid_r || bus.out_ready);
    assign in_hs      = (state == S_RESTORE) && bus.in_valid;

    assign bus.rf_s_addr = ptr;
    assign bus.rf_d_addr = ptr;
    assign bus.rf_d      = bus.in_data;
    // Register 0 is hardwired in the regfile: its word is consumed but never written.
    assign bus.rf_d_en   = in_hs && (ptr != '0);
    assign bus.in_ready  = (state == S_RESTORE);
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;

    assign busy = (state == S_SAVE) || (state == S_DRAIN) || (state == S_RESTORE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            ptr         <= '0;
            end_reg     <= '0;
            word_count  <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ptr        <= first_reg;
                        end_reg    <= last_reg;
                        word_count <= '0;
                        if (first_reg > last_reg) state <= S_DONE;
                        else if (mode)            state <= S_RESTORE;
                        else                      state <= S_SAVE;
                    end
                end
                S_SAVE: begin
                    if (capture) begin
                        out_data_r  <= bus.rf_s_data;
                        out_valid_r <= 1'b1;
                        word_count  <= word_count + WC_ONE;
                        if (ptr == end_reg) state <= S_DRAIN;
                        else                ptr   <= ptr + PTR_ONE;
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_RESTORE: begin
                    if (bus.in_valid) begin
                        word_count <= word_count + WC_ONE;
                        if (ptr == end_reg) state <= S_DONE;
                        else                ptr   <= ptr + PTR_ONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CTX_CHECKSUM_EN
    logic [DATA_W-1:0] csum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)           csum <= '0;
        else if (cmd_accept) csum <= '0;
        else if (capture)    csum <= csum ^ bus.rf_s_data;
        else if (in_hs)      csum <= csum ^ bus.in_data;
    end

    assign checksum = csum;
`else
    assign checksum = '0;
`endif
endmodule

// File: tb/tb_regfile_ctx_engine.sv
// Randomized bench for regfile_ctx_engine: a behavioural regfile plus a per-command expectation
// model (beat list, write list, count, XOR) checked every cycle by one negedge compare process.
module tb_regfile_ctx_engine;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] first_reg = '0;
    logic [AW-1:0] last_reg = '0;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;
    logic [DW-1:0] checksum;

    regfile_ctx_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    regfile_ctx_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .first_reg  (first_reg),
        .last_reg   (last_reg),
        .busy       (busy),
        .done       (done),
        .word_count (word_count),
        .checksum   (checksum),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Behavioural register file: async read, sync write, with a bench-side preload port.
    logic [DW-1:0] rf [32];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;
    assign bus.rf_s_data = rf[bus.rf_s_addr];
    always @(posedge clk) begin
        if (pre_we)           rf[pre_addr] <= pre_data;
        else if (bus.rf_d_en) rf[bus.rf_d_addr] <= bus.rf_d;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cmd_seq = 0;
    int done_seq = 0;
    bit exp_mode = 1'b0;
    int exp_first = 0;
    int exp_n = 0;
    logic [DW-1:0] exp_cs = '0;
    logic [DW-1:0] exp_beats [32];
    logic [DW-1:0] cmd_words [32];
    logic [DW-1:0] cap [32];
    int beat_idx = 0;
    int hs_count = 0;
    int lat = 0;
    int last_lat = 0;
    int hold_wc = 0;
    bit held = 1'b0;
    logic [DW-1:0] held_data = '0;
    int ready_pat = 0;
    bit valid_gaps = 1'b0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stream partner: out_ready pattern and the RESTORE word source.
    initial begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        forever begin
            @(posedge clk); #2;
            cyc++;
            case (ready_pat)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = (cyc % 3 == 0);
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
            if (cmd_seq != done_seq && exp_mode && hs_count < exp_n) begin
                bus.in_valid = valid_gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.in_data  = cmd_words[hs_count];
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = $urandom;
            end
        end
    end

    // Single compare process, sampling mid-cycle.
    always @(negedge clk) begin
        int a;
        if (reset) begin
            beat_idx = 0; hs_count = 0; held = 1'b0; lat = 0; hold_wc = 0;
            done_seq = cmd_seq;
        end else begin
            if (bus.out_valid) begin
                if (held) chk("out_hold", bus.out_data, held_data);
                if (bus.out_ready) begin
                    if (!exp_mode && beat_idx < exp_n && cmd_seq != done_seq)
                        chk("save_beat", bus.out_data, exp_beats[beat_idx]);
                    else
                        chk("save_beat_unexpected", bus.out_valid, 1'b0);
                    if (beat_idx < 32) cap[beat_idx] = bus.out_data;
                    beat_idx++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    held_data = bus.out_data;
                end
            end else held = 1'b0;

            if (bus.in_valid && bus.in_ready) begin
                if (exp_mode && hs_count < exp_n && cmd_seq != done_seq) begin
                    a = exp_first + hs_count;
                    chk("rf_d_en", bus.rf_d_en, a != 0);
                    if (a != 0) begin
                        chk("rf_d_addr", bus.rf_d_addr, a);
                        chk("rf_d", bus.rf_d, cmd_words[hs_count]);
                    end
                end else chk("restore_unexpected", bus.in_ready, 1'b0);
                hs_count++;
            end else chk("rf_d_en_stray", bus.rf_d_en, 1'b0);

            if (cmd_seq == done_seq) begin
                chk("idle_outputs", {busy, done, bus.out_valid, bus.in_ready, word_count},
                    {4'b0000, hold_wc[AW:0]});
            end else if (done) begin
                chk("done_word_count", word_count, exp_n);
                chk("done_checksum", checksum, exp_cs);
                chk("done_busy", busy, 1'b0);
                chk("done_beats", beat_idx, exp_mode ? 0 : exp_n);
                chk("done_words", hs_count, exp_mode ? exp_n : 0);
                last_lat = lat; lat = 0; hold_wc = exp_n;
                beat_idx = 0; hs_count = 0;
                done_seq = cmd_seq;
            end else begin
                chk("busy", busy, 1'b1);
                lat++;
            end
        end
    end

    task automatic preload(input int a, input logic [DW-1:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_addr = a[AW-1:0]; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic issue(input bit m, input int f, input int l, input bit keep_words);
        logic [DW-1:0] cs;
        cs = '0;
        exp_mode = m; exp_first = f;
        exp_n = (f > l) ? 0 : l - f + 1;
        for (int i = 0; i < exp_n; i++) begin
            if (m) begin
                if (!keep_words) cmd_words[i] = $urandom;
                cs ^= cmd_words[i];
            end else begin
                exp_beats[i] = rf[f + i];
                cs ^= exp_beats[i];
            end
        end
`ifdef CTX_CHECKSUM_EN
        exp_cs = cs;
`else
        exp_cs = '0;
`endif
        @(posedge clk); #1;
        start = 1'b1; mode = m; first_reg = f[AW-1:0]; last_reg = l[AW-1:0];
        @(posedge clk); #1;
        start = 1'b0; mode = 1'($urandom); first_reg = AW'($urandom); last_reg = AW'($urandom);
        cmd_seq++;
    endtask

    // Waits for the done pulse; optionally pokes start/operands while the engine is busy.
    task automatic wait_done(input bit noisy);
        int c;
        c = 0;
        while (cmd_seq != done_seq && c < 3000) begin
            @(posedge clk); #1;
            c++;
            start = noisy && (cmd_seq != done_seq) ? 1'($urandom_range(0, 1)) : 1'b0;
            mode = 1'($urandom); first_reg = AW'($urandom); last_reg = AW'($urandom);
        end
        start = 1'b0;
        chk("done_timeout", cmd_seq == done_seq, 1'b1);
        if (cmd_seq != done_seq) begin
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end
    endtask

    initial begin
        logic [DW-1:0] old_rf [32];
        logic [DW-1:0] words_snap [32];
        int f, l, c;

        for (int i = 0; i < 32; i++) preload(i, (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
        #1;
        chk("reset_state", {busy, done, bus.out_valid, bus.in_ready, bus.rf_d_en, word_count,
                            bus.out_data, checksum}, '0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Full SAVE of 1..31 with continuous ready.
        ready_pat = 0;
        issue(1'b0, 1, 31, 1'b0);
        wait_done(1'b0);
        chk("save31_count", word_count, 31);
        for (int i = 0; i < 31; i++) chk("save31_beat", cap[i], 32'h1000_0001 + 32'(i));

        // Short SAVE under a 1,0,0 ready pattern.
        ready_pat = 1;
        issue(1'b0, 4, 6, 1'b0);
        wait_done(1'b0);
        chk("save3_count", word_count, 3);
        for (int i = 0; i < 3; i++) chk("save3_beat", cap[i], 32'h1000_0004 + 32'(i));

        // Whole file: 32 words, pointer stops at 31 without wrapping.
        ready_pat = 2;
        issue(1'b0, 0, 31, 1'b0);
        wait_done(1'b0);
        chk("save32_count", word_count, 32);
        chk("save32_first", cap[0], 32'h0);
        chk("save32_last", cap[31], 32'h1000_001F);

        // RESTORE 0..3 with gaps; reg 0 is consumed but not written.
        valid_gaps = 1'b1;
        for (int i = 0; i < 4; i++) cmd_words[i] = 32'hA000_0000 + 32'(i);
        issue(1'b1, 0, 3, 1'b1);
        wait_done(1'b0);
        chk("restore4_count", word_count, 4);
        chk("restore4_reg0", rf[0], 32'h0);
        for (int i = 1; i < 4; i++) chk("restore4_reg", rf[i], 32'hA000_0000 + 32'(i));

        // Inverted range: done on the first cycle after start, nothing transferred.
        issue(1'($urandom), 7, 2, 1'b0);
        wait_done(1'b0);
        chk("empty_count", word_count, 0);
        chk("empty_latency", last_lat, 0);

        // Checksum of three hand-picked words.
        preload(1, 32'hF0F0_0000);
        preload(2, 32'h0F0F_0000);
        preload(3, 32'h0000_00FF);
        ready_pat = 0;
        issue(1'b0, 1, 3, 1'b0);
        wait_done(1'b0);
        chk("csum_count", word_count, 3);
`ifdef CTX_CHECKSUM_EN
        chk("csum_value", checksum, 32'hFFFF_00FF);
`else
        chk("csum_value", checksum, 32'h0);
`endif

        // Reset in the middle of a 5-word RESTORE after two words have landed.
        valid_gaps = 1'b0;
        for (int i = 0; i < 32; i++) old_rf[i] = rf[i];
        issue(1'b1, 10, 14, 1'b0);
        for (int i = 0; i < 5; i++) words_snap[i] = cmd_words[i];
        c = 0;
        while (hs_count < 2 && c < 100) begin
            @(negedge clk); #1;
            c++;
        end
        chk("midreset_reach", hs_count, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("midreset_outputs", {busy, done, bus.out_valid, bus.in_ready, bus.rf_d_en, word_count,
                                 bus.out_data, checksum}, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midreset_reg10", rf[10], words_snap[0]);
        chk("midreset_reg11", rf[11], words_snap[1]);
        for (int i = 12; i < 15; i++) chk("midreset_untouched", rf[i], old_rf[i]);

        issue(1'b1, 10, 14, 1'b0);
        wait_done(1'b0);
        chk("after_reset_count", word_count, 5);
        for (int i = 0; i < 5; i++) chk("after_reset_reg", rf[10 + i], cmd_words[i]);

        // Random commands, with start toggling while busy.
        for (int k = 0; k < 12; k++) begin
            ready_pat  = $urandom_range(0, 2);
            valid_gaps = 1'($urandom);
            f = $urandom_range(0, 31);
            l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(f, 31);
            issue(1'($urandom), f, l, 1'b0);
            wait_done(1'b1);
            if (exp_mode)
                for (int i = 0; i < exp_n; i++)
                    if (f + i != 0) chk("rand_restore_reg", rf[f + i], cmd_words[i]);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
